// File: rtl/topo_sort_scheduler.sv
// Topological sort scheduler (Kahn's algorithm).
// Walks an external in-degree table and adjacency store, keeps a FIFO of
// ready nodes and emits nodes in topological order. Reports an error when
// not every node could be emitted (cycle) or the ready queue overflowed.
module topo_sort_scheduler #(
  parameter int MAX_NODES  = 1024,
  parameter int NODE_WIDTH = $clog2(MAX_NODES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NODE_WIDTH:0]   node_count,
  output logic [NODE_WIDTH-1:0] node_sel,
  output logic                  decrement_degree,
  input  logic [NODE_WIDTH-1:0] node_degree,
  output logic                  adj_req,
  output logic [NODE_WIDTH-1:0] adj_node,
  output logic [NODE_WIDTH-1:0] adj_idx,
  input  logic                  adj_rsp_valid,
  input  logic [NODE_WIDTH-1:0] adj_dst,
  input  logic                  adj_last,
  input  logic                  adj_none,
  output logic                  order_valid,
  output logic [NODE_WIDTH-1:0] order_node,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    POP,
    FETCH,
    WAIT,
    DEC,
    CHECK,
    FIN
  } state_t;

  localparam logic [NODE_WIDTH:0]   CNT_ONE  = (NODE_WIDTH+1)'(1);
  localparam logic [NODE_WIDTH-1:0] IDX_ONE  = NODE_WIDTH'(1);
  localparam logic [NODE_WIDTH-1:0] PTR_LAST = NODE_WIDTH'(MAX_NODES - 1);
  localparam logic [NODE_WIDTH:0]   Q_DEPTH  = (NODE_WIDTH+1)'(MAX_NODES);

  state_t                state_reg, state_next;
  logic [NODE_WIDTH:0]   cnt_reg, cnt_next;
  logic [NODE_WIDTH:0]   scan_idx_reg, scan_idx_next;
  logic [NODE_WIDTH:0]   emit_reg, emit_next;
  logic [NODE_WIDTH-1:0] cur_node_reg, cur_node_next;
  logic [NODE_WIDTH-1:0] edge_idx_reg, edge_idx_next;
  logic [NODE_WIDTH-1:0] dst_reg, dst_next;
  logic                  last_reg, last_next;

  // Ready queue: plain array storage, pointers wrap at MAX_NODES.
  logic [NODE_WIDTH-1:0] q_mem [MAX_NODES];
  logic [NODE_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [NODE_WIDTH:0]   q_count_reg;
  logic                  overflow_reg;

  logic                  push_en;
  logic [NODE_WIDTH-1:0] push_data;
  logic                  pop_en;
  logic                  q_clear;
  logic                  q_full;
  logic                  q_empty;
  logic [NODE_WIDTH-1:0] q_head;
  logic [NODE_WIDTH:0]   scan_prev;

  assign q_full    = (q_count_reg == Q_DEPTH);
  assign q_empty   = (q_count_reg == '0);
  assign q_head    = q_mem[rd_ptr_reg];
  // The node whose degree arrives this cycle was selected one cycle earlier.
  assign scan_prev = scan_idx_reg - CNT_ONE;

  function automatic logic [NODE_WIDTH-1:0] ptr_inc(input logic [NODE_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + IDX_ONE;
  endfunction

  // Control state and per-sort bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      scan_idx_reg <= '0;
      emit_reg     <= '0;
      cur_node_reg <= '0;
      edge_idx_reg <= '0;
      dst_reg      <= '0;
      last_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      scan_idx_reg <= scan_idx_next;
      emit_reg     <= emit_next;
      cur_node_reg <= cur_node_next;
      edge_idx_reg <= edge_idx_next;
      dst_reg      <= dst_next;
      last_reg     <= last_next;
    end
  end

  // Queue pointers, occupancy and sticky overflow; a full queue drops the push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      q_count_reg  <= '0;
      overflow_reg <= 1'b0;
    end else if (q_clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      q_count_reg  <= '0;
      overflow_reg <= 1'b0;
    end else if (push_en) begin
      if (q_full) begin
        overflow_reg <= 1'b1;
      end else begin
        wr_ptr_reg  <= ptr_inc(wr_ptr_reg);
        q_count_reg <= q_count_reg + CNT_ONE;
      end
    end else if (pop_en) begin
      rd_ptr_reg  <= ptr_inc(rd_ptr_reg);
      q_count_reg <= q_count_reg - CNT_ONE;
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    if (push_en && !q_full) begin
      q_mem[wr_ptr_reg] <= push_data;
    end
  end

  // Next-state, queue control and output decode.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    scan_idx_next    = scan_idx_reg;
    emit_next        = emit_reg;
    cur_node_next    = cur_node_reg;
    edge_idx_next    = edge_idx_reg;
    dst_next         = dst_reg;
    last_next        = last_reg;
    push_en          = 1'b0;
    push_data        = '0;
    pop_en           = 1'b0;
    q_clear          = 1'b0;
    node_sel         = '0;
    decrement_degree = 1'b0;
    adj_req          = 1'b0;
    adj_node         = '0;
    adj_idx          = '0;
    order_valid      = 1'b0;
    order_node       = '0;
    done             = 1'b0;
    error            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          cnt_next      = node_count;
          scan_idx_next = '0;
          emit_next     = '0;
          q_clear       = 1'b1;
          state_next    = SCAN;
        end
      end

      SCAN: begin
        if (scan_idx_reg < cnt_reg) begin
          node_sel = scan_idx_reg[NODE_WIDTH-1:0];
        end
        if ((scan_idx_reg != '0) && (node_degree == '0)) begin
          push_en   = 1'b1;
          push_data = scan_prev[NODE_WIDTH-1:0];
        end
        if (scan_idx_reg == cnt_reg) begin
          state_next = POP;
        end else begin
          scan_idx_next = scan_idx_reg + CNT_ONE;
        end
      end

      POP: begin
        if (!q_empty) begin
          pop_en        = 1'b1;
          order_valid   = 1'b1;
          order_node    = q_head;
          cur_node_next = q_head;
          emit_next     = emit_reg + CNT_ONE;
          edge_idx_next = '0;
          state_next    = FETCH;
        end else begin
          state_next = FIN;
        end
      end

      FETCH: begin
        adj_req    = 1'b1;
        adj_node   = cur_node_reg;
        adj_idx    = edge_idx_reg;
        state_next = WAIT;
      end

      WAIT: begin
        if (adj_rsp_valid) begin
          if (adj_none) begin
            state_next = POP;
          end else begin
            dst_next   = adj_dst;
            last_next  = adj_last;
            state_next = DEC;
          end
        end
      end

      DEC: begin
        node_sel         = dst_reg;
        decrement_degree = 1'b1;
        state_next       = CHECK;
      end

      CHECK: begin
        if (node_degree == '0) begin
          push_en   = 1'b1;
          push_data = dst_reg;
        end
        if (last_reg) begin
          state_next = POP;
        end else begin
          edge_idx_next = edge_idx_reg + IDX_ONE;
          state_next    = FETCH;
        end
      end

      FIN: begin
        done       = 1'b1;
        error      = (emit_reg != cnt_reg) || overflow_reg;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_topo_sort_scheduler.sv
// Bench for topo_sort_scheduler: in-degree table and adjacency store models,
// table-driven graph vectors plus reset-in-WAIT and start-during-SCAN sequences.
module tb_topo_sort_scheduler;

  localparam int MN = 8;
  localparam int NW = 3;
  localparam int NV = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NW:0]   node_count = '0;
  logic [NW-1:0] node_sel;
  logic          decrement_degree;
  logic [NW-1:0] node_degree = '0;
  logic          adj_req;
  logic [NW-1:0] adj_node;
  logic [NW-1:0] adj_idx;
  logic          adj_rsp_valid = 1'b0;
  logic [NW-1:0] adj_dst = '0;
  logic          adj_last = 1'b0;
  logic          adj_none = 1'b0;
  logic          order_valid;
  logic [NW-1:0] order_node;
  logic          done;
  logic          error;

  topo_sort_scheduler #(.MAX_NODES(MN)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .node_count       (node_count),
    .node_sel         (node_sel),
    .decrement_degree (decrement_degree),
    .node_degree      (node_degree),
    .adj_req          (adj_req),
    .adj_node         (adj_node),
    .adj_idx          (adj_idx),
    .adj_rsp_valid    (adj_rsp_valid),
    .adj_dst          (adj_dst),
    .adj_last         (adj_last),
    .adj_none         (adj_none),
    .order_valid      (order_valid),
    .order_node       (order_node),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  // In-degree table model: registered read, minus one when decremented.
  int   deg_tbl [MN];
  int   load_deg [MN];
  logic load_en = 1'b0;
  always @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < MN; k++) deg_tbl[k] <= load_deg[k];
    end else begin
      node_degree <= NW'(deg_tbl[node_sel] - (decrement_degree ? 1 : 0));
      if (decrement_degree) deg_tbl[node_sel] <= deg_tbl[node_sel] - 1;
    end
  end

  // Adjacency store model with a fixed response latency.
  int            adj_len [MN];
  int            adj_list [MN][MN];
  int            lat = 1;
  logic          pend = 1'b0;
  int            pend_cnt = 0;
  logic [NW-1:0] pend_node = '0;
  logic [NW-1:0] pend_idx = '0;
  always @(posedge clk) begin
    adj_rsp_valid <= 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        adj_rsp_valid <= 1'b1;
        adj_none      <= (adj_len[pend_node] == 0);
        adj_dst       <= (adj_len[pend_node] == 0) ? NW'(MN - 1) : NW'(adj_list[pend_node][pend_idx]);
        adj_last      <= (int'(pend_idx) == adj_len[pend_node] - 1);
        pend          <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
    if (adj_req) begin
      pend      <= 1'b1;
      pend_cnt  <= lat - 1;
      pend_node <= adj_node;
      pend_idx  <= adj_idx;
    end
  end

  // Output monitor: records emitted order, done pulses and protocol anomalies.
  int            cyc = 0;
  int            mon_err = 0;
  int            got [512];
  int            got_n = 0;
  int            done_n = 0;
  logic          last_err = 1'b0;
  int            last_dec = -100;
  int            dec_cnt [MN];
  int            emit_dec [MN];
  logic          outst = 1'b0;
  logic [NW-1:0] last_emit = '0;
  always @(negedge clk) begin
    cyc++;
    if (order_valid) begin
      if (got_n < 512) got[got_n] = int'(order_node);
      got_n++;
      last_emit = order_node;
      emit_dec[order_node] = dec_cnt[order_node];
    end
    if (done) begin
      done_n++;
      last_err = error;
    end
    if (decrement_degree) begin
      if (cyc - last_dec < 2) begin
        mon_err++;
        $display("protocol: decrements %0d cycles apart at cycle %0d", cyc - last_dec, cyc);
      end
      last_dec = cyc;
      dec_cnt[node_sel]++;
    end
    if (adj_rsp_valid) outst = 1'b0;
    if (adj_req) begin
      if (outst) begin
        mon_err++;
        $display("protocol: second outstanding request at cycle %0d", cyc);
      end
      if (adj_node != last_emit) begin
        mon_err++;
        $display("protocol: request for node %0d, last emitted %0d", adj_node, last_emit);
      end
      if ((adj_len[adj_node] == 0 && adj_idx != 0) ||
          (adj_len[adj_node] > 0 && int'(adj_idx) >= adj_len[adj_node])) begin
        mon_err++;
        $display("protocol: bad edge index %0d for node %0d", adj_idx, adj_node);
      end
      outst = 1'b1;
    end
  end

  typedef struct {
    int n;
    int deg [8];
    int ne;
    int esrc [8];
    int edst [8];
    int lat;
    int olen;
    int ord [8];
    int err;
  } vec_t;

  vec_t  vecs [NV];
  string names [NV];

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_zero(input string name);
    check(name, int'({order_valid, done, error, adj_req, decrement_degree,
                      node_sel, order_node, adj_node, adj_idx}), 0);
  endtask

  task automatic load_case(input int k);
    for (int i = 0; i < MN; i++) begin
      adj_len[i]  = 0;
      load_deg[i] = vecs[k].deg[i];
    end
    for (int e = 0; e < vecs[k].ne; e++) begin
      adj_list[vecs[k].esrc[e]][adj_len[vecs[k].esrc[e]]] = vecs[k].edst[e];
      adj_len[vecs[k].esrc[e]]++;
    end
    lat = vecs[k].lat;
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic run_case(input int k, input bit poke);
    int    g0, d0, m0, dec5_0;
    bit    seen;
    string tag;
    tag = poke ? {names[k], "_poke"} : names[k];
    load_case(k);
    g0 = got_n; d0 = done_n; m0 = mon_err; dec5_0 = dec_cnt[5];
    start = 1'b1;
    node_count = (NW+1)'(vecs[k].n);
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      @(negedge clk);
      start = 1'b1;
      node_count = (NW+1)'(1);
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      #1;
      if (done_n != d0) seen = 1'b1;
    end
    check({tag, ".done_seen"}, int'(seen), 1);
    repeat (20) @(negedge clk);
    check({tag, ".done_pulses"}, done_n - d0, 1);
    check({tag, ".error"}, int'(last_err), vecs[k].err);
    check({tag, ".emitted"}, got_n - g0, vecs[k].olen);
    for (int i = 0; i < vecs[k].olen; i++) begin
      check($sformatf("%s.order[%0d]", tag, i),
            (g0 + i < got_n) ? got[g0 + i] : -1, vecs[k].ord[i]);
    end
    check({tag, ".protocol"}, mon_err - m0, 0);
    if (names[k] == "multi") begin
      check({tag, ".dec_to_5"}, dec_cnt[5] - dec5_0, 2);
      check({tag, ".emit5_after_dec"}, emit_dec[5] - dec5_0, 2);
    end
  endtask

  initial begin
    names[0] = "chain";
    vecs[0].n = 3; vecs[0].deg = '{0, 1, 1, 0, 0, 0, 0, 0};
    vecs[0].ne = 2; vecs[0].esrc = '{0, 1, 0, 0, 0, 0, 0, 0}; vecs[0].edst = '{1, 2, 0, 0, 0, 0, 0, 0};
    vecs[0].lat = 1; vecs[0].olen = 3; vecs[0].ord = '{0, 1, 2, 0, 0, 0, 0, 0}; vecs[0].err = 0;

    names[1] = "diamond";
    vecs[1].n = 4; vecs[1].deg = '{0, 1, 1, 2, 0, 0, 0, 0};
    vecs[1].ne = 4; vecs[1].esrc = '{0, 0, 1, 2, 0, 0, 0, 0}; vecs[1].edst = '{1, 2, 3, 3, 0, 0, 0, 0};
    vecs[1].lat = 2; vecs[1].olen = 4; vecs[1].ord = '{0, 1, 2, 3, 0, 0, 0, 0}; vecs[1].err = 0;

    names[2] = "multi";
    vecs[2].n = 6; vecs[2].deg = '{0, 0, 0, 0, 0, 2, 0, 0};
    vecs[2].ne = 2; vecs[2].esrc = '{0, 0, 0, 0, 0, 0, 0, 0}; vecs[2].edst = '{5, 5, 0, 0, 0, 0, 0, 0};
    vecs[2].lat = 1; vecs[2].olen = 6; vecs[2].ord = '{0, 1, 2, 3, 4, 5, 0, 0}; vecs[2].err = 0;

    names[3] = "cycle";
    vecs[3].n = 3; vecs[3].deg = '{0, 1, 1, 0, 0, 0, 0, 0};
    vecs[3].ne = 2; vecs[3].esrc = '{1, 2, 0, 0, 0, 0, 0, 0}; vecs[3].edst = '{2, 1, 0, 0, 0, 0, 0, 0};
    vecs[3].lat = 3; vecs[3].olen = 1; vecs[3].ord = '{0, 0, 0, 0, 0, 0, 0, 0}; vecs[3].err = 1;

    names[4] = "single";
    vecs[4].n = 1; vecs[4].deg = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].ne = 0; vecs[4].esrc = '{0, 0, 0, 0, 0, 0, 0, 0}; vecs[4].edst = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].lat = 1; vecs[4].olen = 1; vecs[4].ord = '{0, 0, 0, 0, 0, 0, 0, 0}; vecs[4].err = 0;

    names[5] = "full";
    vecs[5].n = 8; vecs[5].deg = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5].ne = 0; vecs[5].esrc = '{0, 0, 0, 0, 0, 0, 0, 0}; vecs[5].edst = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5].lat = 2; vecs[5].olen = 8; vecs[5].ord = '{0, 1, 2, 3, 4, 5, 6, 7}; vecs[5].err = 0;

    names[6] = "reverse";
    vecs[6].n = 4; vecs[6].deg = '{1, 1, 1, 0, 0, 0, 0, 0};
    vecs[6].ne = 3; vecs[6].esrc = '{3, 2, 1, 0, 0, 0, 0, 0}; vecs[6].edst = '{2, 1, 0, 0, 0, 0, 0, 0};
    vecs[6].lat = 1; vecs[6].olen = 4; vecs[6].ord = '{3, 2, 1, 0, 0, 0, 0, 0}; vecs[6].err = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_zero("idle_outputs");

    for (int k = 0; k < NV; k++) run_case(k, 1'b0);

    // Abort a sort while waiting on a slow adjacency response.
    begin
      int  d0;
      bit  saw_req;
      load_case(1);
      lat = 6;
      start = 1'b1;
      node_count = (NW+1)'(4);
      @(negedge clk);
      start = 1'b0;
      saw_req = 1'b0;
      for (int t = 0; t < 200 && !saw_req; t++) begin
        @(negedge clk);
        #1;
        if (adj_req) saw_req = 1'b1;
      end
      check("abort.req_seen", int'(saw_req), 1);
      @(negedge clk);
      #1;
      check("abort.waiting_no_req", int'(adj_req), 0);
      d0 = done_n;
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("abort.outputs_in_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      #1;
      check("abort.no_done", done_n - d0, 0);
      check_zero("abort.idle_after_late_rsp");
      run_case(0, 1'b0);
    end

    // Start held high during SCAN must not restart the sort.
    run_case(0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/topo_sort_scheduler.md
TOPO_SORT_SCHEDULER -- requirements
Module: topo_sort_scheduler

Interface
REQ-001 SHALL have parameter MAX_NODES, default 1024, maximum node count.
REQ-002 SHALL have parameter NODE_WIDTH, default $clog2(MAX_NODES), node index width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: begin sort; sampled only in IDLE.
REQ-006 SHALL have port node_count, input, NODE_WIDTH+1 bits: node count, 1..MAX_NODES; sampled with start.
REQ-007 SHALL have port node_sel, output, NODE_WIDTH bits: in-degree table select.
REQ-008 SHALL have port decrement_degree, output, 1 bit: decrement the degree of node_sel.
REQ-009 SHALL have port node_degree, input, NODE_WIDTH bits: table[node_sel of previous cycle], minus 1 if that cycle decremented.
REQ-010 SHALL have port adj_req, output, 1 bit: adjacency read request.
REQ-011 SHALL have port adj_node, output, NODE_WIDTH bits: source node of the request.
REQ-012 SHALL have port adj_idx, output, NODE_WIDTH bits: edge index within the source node's list.
REQ-013 SHALL have port adj_rsp_valid, input, 1 bit: response valid.
REQ-014 SHALL have port adj_dst, input, NODE_WIDTH bits: destination node of the edge.
REQ-015 SHALL have port adj_last, input, 1 bit: this edge is the node's last edge.
REQ-016 SHALL have port adj_none, input, 1 bit: node has no out-edges; adj_dst is ignored.
REQ-017 SHALL have port order_valid, output, 1 bit: order_node valid, one cycle.
REQ-018 SHALL have port order_node, output, NODE_WIDTH bits: next node in topological order.
REQ-019 SHALL have port done, output, 1 bit: one-cycle pulse at completion.
REQ-020 SHALL have port error, output, 1 bit: cycle or overflow detected; valid with done.

Function
REQ-021 SHALL implement states IDLE, SCAN, POP, FETCH, WAIT, DEC, CHECK, FIN.
REQ-022 IDLE SHALL move to SCAN when start=1 and latch node_count; start in any other state SHALL be ignored.
REQ-023 SCAN SHALL drive node_sel=i, decrement_degree=0 for i=0..node_count-1, one per cycle.
REQ-024 SCAN SHALL push i into the internal queue when node_degree==0 in cycle i+1.
REQ-025 SCAN SHALL go to POP one cycle after the last select.
REQ-026 POP with a non-empty queue SHALL pop node n, pulse order_valid with order_node=n, increment the emitted count, set edge index 0, and go to FETCH.
REQ-027 POP with an empty queue SHALL go to FIN.
REQ-028 FETCH SHALL assert adj_req for one cycle with adj_node=n and adj_idx=edge index, then go to WAIT.
REQ-029 WAIT SHALL hold with adj_req=0, with no timeout, until adj_rsp_valid; at most one request SHALL be outstanding.
REQ-030 On a response with adj_none=1, WAIT SHALL go to POP.
REQ-031 On any other response, WAIT SHALL latch adj_dst and adj_last, then go to DEC.
REQ-032 DEC SHALL drive node_sel=adj_dst, decrement_degree=1 for exactly one cycle.
REQ-033 CHECK, in the next cycle, SHALL push adj_dst if node_degree==0.
REQ-034 From CHECK, adj_last=1 SHALL lead to POP; otherwise the edge index SHALL increment and the state SHALL go to FETCH.
REQ-035 Decrement issue SHALL never occur in two consecutive cycles: read-after-write hazard on the table.
REQ-036 FETCH/WAIT SHALL guarantee at least one idle table cycle between decrements; multi-edges to the same dst SHALL yield correct counts.
REQ-037 Outside SCAN/DEC, decrement_degree SHALL be 0; node_sel may hold any value.
REQ-038 The queue SHALL be a FIFO of depth MAX_NODES with pointers wrapping modulo MAX_NODES; order SHALL be push order.
REQ-039 A push when the queue is full SHALL be dropped and SHALL set a sticky overflow flag.
REQ-040 A push and a pop in the same cycle are impossible by construction: they occur in different states.
REQ-041 FIN SHALL pulse done and drive error=1 if emitted count != node_count or overflow is set, else error=0, then return to IDLE.
REQ-042 Emitted count width SHALL be NODE_WIDTH+1 bits; no wrap SHALL occur for node_count <= MAX_NODES.

Reset
REQ-043 rst_n=0 SHALL immediately force state IDLE, clear the queue pointers, counters and overflow flag, and drive all outputs to 0.
REQ-044 Reset mid-operation SHALL abort the sort; the in-degree table is not restored and the caller reloads it before the next start.
REQ-045 A late adj_rsp_valid after reset SHALL be ignored in IDLE.

Verification
REQ-046 Chain 0->1->2, degrees {0,1,1}, node_count=3 -> order 0,1,2; done with error=0.
REQ-047 Diamond 0->1, 0->2, 1->3, 2->3 -> order 0,1,2,3; node 3 degree 2->1->0; pushed once.
REQ-048 Multi-edge 0->5, 0->5, node_count=6 -> decrements to node 5 spaced >= 2 cycles apart; node 5 emitted exactly once, after its second decrement.
REQ-049 Cycle 1->2, 2->1, isolated node 0, node_count=3 -> only 0 emitted; done with error=1.
REQ-050 rst_n pulsed low during WAIT -> outputs 0 at once, state IDLE; subsequent start with the chain case -> correct order.
REQ-051 start pulsed during SCAN -> ignored; exactly one done pulse per accepted start.
